// File: rtl/mem_access_arbiter_pkg.sv
// Shared definitions for the single-port memory access arbiter.
// - DefaultAddrW / DefaultDataW : bus widths used by the pipeline
// - arb_state_e                 : arbiter FSM states
package mem_access_arbiter_pkg;

  localparam int unsigned DefaultAddrW = 64;
  localparam int unsigned DefaultDataW = 64;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StIfBusy  = 2'd1,
    StMemBusy = 2'd2,
    StIfDrop  = 2'd3
  } arb_state_e;

endpackage

// File: rtl/mem_access_arbiter_if.sv
// Signal bundle between the IF/MEM pipeline stages, the arbiter and the memory bus.
// - slave  : arbiter view (takes stage requests and bus_ready/rdata, drives stalls and bus_*)
// - master : environment view (pipeline stages plus memory), the mirror image
interface mem_access_arbiter_if #(
  parameter int unsigned ADDR_W = mem_access_arbiter_pkg::DefaultAddrW,
  parameter int unsigned DATA_W = mem_access_arbiter_pkg::DefaultDataW
) ();

  logic                  if_req;
  logic [ADDR_W-1:0]     if_addr;
  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_W-1:0]     mem_addr;
  logic [DATA_W-1:0]     mem_wdata;
  logic [DATA_W/8-1:0]   mem_wstrb;
  logic                  switch_mode;
  logic                  if_stall;
  logic                  mem_stall;
  logic [DATA_W-1:0]     if_rdata;
  logic [DATA_W-1:0]     mem_rdata;
  logic                  bus_valid;
  logic                  bus_we;
  logic [ADDR_W-1:0]     bus_addr;
  logic [DATA_W-1:0]     bus_wdata;
  logic [DATA_W/8-1:0]   bus_wstrb;
  logic                  bus_ready;
  logic [DATA_W-1:0]     bus_rdata;

  modport slave (
    input  if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb, switch_mode,
    input  bus_ready, bus_rdata,
    output if_stall, mem_stall, if_rdata, mem_rdata,
    output bus_valid, bus_we, bus_addr, bus_wdata, bus_wstrb
  );

  modport master (
    output if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb, switch_mode,
    output bus_ready, bus_rdata,
    input  if_stall, mem_stall, if_rdata, mem_rdata,
    input  bus_valid, bus_we, bus_addr, bus_wdata, bus_wstrb
  );

endinterface

// File: rtl/mem_access_arbiter_bus_req_latch.sv
// Request capture register for the arbiter: holds the bus command (we/addr/wdata/wstrb)
// for the whole transaction so bus_* stay stable until bus_ready.
// - clk_i, rst_i : clock, asynchronous active-high reset (clears all fields)
// - load_i       : capture the *_i fields this cycle
// - *_i / *_o    : command fields in / held command fields out
module bus_req_latch #(
  parameter int unsigned ADDR_W = mem_access_arbiter_pkg::DefaultAddrW,
  parameter int unsigned DATA_W = mem_access_arbiter_pkg::DefaultDataW
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                load_i,
  input  logic                we_i,
  input  logic [ADDR_W-1:0]   addr_i,
  input  logic [DATA_W-1:0]   wdata_i,
  input  logic [DATA_W/8-1:0] wstrb_i,
  output logic                we_o,
  output logic [ADDR_W-1:0]   addr_o,
  output logic [DATA_W-1:0]   wdata_o,
  output logic [DATA_W/8-1:0] wstrb_o
);

  logic                we_d,    we_q;
  logic [ADDR_W-1:0]   addr_d,  addr_q;
  logic [DATA_W-1:0]   wdata_d, wdata_q;
  logic [DATA_W/8-1:0] wstrb_d, wstrb_q;

  always_comb begin
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    if (load_i) begin
      we_d    = we_i;
      addr_d  = addr_i;
      wdata_d = wdata_i;
      wstrb_d = wstrb_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
    end else begin
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
    end
  end

  assign we_o    = we_q;
  assign addr_o  = addr_q;
  assign wdata_o = wdata_q;
  assign wstrb_o = wstrb_q;

endmodule

// File: rtl/mem_access_arbiter.sv
// Single-port memory access arbiter between the IF and MEM pipeline stages and one
// valid/ready memory bus. Produces if_stall / mem_stall for the hazard controller.
// - clk, rst : clock, asynchronous active-high reset
// - arb_if   : stage requests, stalls, returned data and the bus command/response
// MEM wins over IF in IDLE (older instruction). A granted fetch cancelled by switch_mode
// keeps its bus request alive until bus_ready, and its response is discarded.
module mem_access_arbiter
  import mem_access_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = DefaultAddrW,
  parameter int unsigned DATA_W = DefaultDataW
) (
  input logic                  clk,
  input logic                  rst,
  mem_access_arbiter_if.slave  arb_if
);

  arb_state_e state_d, state_q;

  logic                grant_mem, grant_if, load;
  logic                ld_we;
  logic [ADDR_W-1:0]   ld_addr;
  logic [DATA_W-1:0]   ld_wdata;
  logic [DATA_W/8-1:0] ld_wstrb;
  logic                if_done, mem_done;

  // Grant decision and the command to capture.
  always_comb begin
    grant_mem = (state_q == StIdle) && arb_if.mem_req;
    grant_if  = (state_q == StIdle) && !arb_if.mem_req && arb_if.if_req && !arb_if.switch_mode;
    load      = grant_mem || grant_if;
    ld_we     = grant_mem && arb_if.mem_we;
    ld_addr   = grant_mem ? arb_if.mem_addr  : arb_if.if_addr;
    ld_wdata  = grant_mem ? arb_if.mem_wdata : '0;
    ld_wstrb  = grant_mem ? arb_if.mem_wstrb : '0;
  end

  bus_req_latch #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_bus_req_latch (
    .clk_i   (clk),
    .rst_i   (rst),
    .load_i  (load),
    .we_i    (ld_we),
    .addr_i  (ld_addr),
    .wdata_i (ld_wdata),
    .wstrb_i (ld_wstrb),
    .we_o    (arb_if.bus_we),
    .addr_o  (arb_if.bus_addr),
    .wdata_o (arb_if.bus_wdata),
    .wstrb_o (arb_if.bus_wstrb)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (grant_mem)     state_d = StMemBusy;
        else if (grant_if) state_d = StIfBusy;
      end
      StIfBusy: begin
        if (arb_if.bus_ready)        state_d = StIdle;
        else if (arb_if.switch_mode) state_d = StIfDrop;
      end
      StMemBusy: begin
        if (arb_if.bus_ready) state_d = StIdle;
      end
      StIfDrop: begin
        if (arb_if.bus_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Async reset returns to IDLE at once, so bus_valid drops in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  always_comb begin
    // A redirect in the completing cycle discards the fetch data.
    if_done          = (state_q == StIfBusy) && arb_if.bus_ready && !arb_if.switch_mode;
    mem_done         = (state_q == StMemBusy) && arb_if.bus_ready;
    arb_if.bus_valid = (state_q != StIdle);
    arb_if.if_stall  = arb_if.if_req && !if_done;
    arb_if.mem_stall = arb_if.mem_req && !mem_done;
    arb_if.if_rdata  = if_done ? arb_if.bus_rdata : '0;
    arb_if.mem_rdata = (mem_done && !arb_if.bus_we) ? arb_if.bus_rdata : '0;
  end

endmodule

// File: tb/tb_mem_access_arbiter.sv
module tb_mem_access_arbiter;

  logic clk;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;
  bit   chk_on = 1'b0;
  bit   if_done_s, mem_done_s;

  mem_access_arbiter_if #(.ADDR_W(64), .DATA_W(64)) bus_if ();

  mem_access_arbiter #(.ADDR_W(64), .DATA_W(64)) dut (
    .clk    (clk),
    .rst    (rst),
    .arb_if (bus_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Transaction-level reference: at most one outstanding bus transaction, its captured
  // command, and whether a redirect has orphaned it.
  bit          m_busy, m_fetch, m_cancel, m_we;
  logic [63:0] m_addr, m_wdata;
  logic [7:0]  m_wstrb;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy <= 0; m_fetch <= 0; m_cancel <= 0; m_we <= 0;
      m_addr <= '0; m_wdata <= '0; m_wstrb <= '0;
    end else if (m_busy) begin
      if (bus_if.bus_ready) m_busy <= 0;
      else if (m_fetch && bus_if.switch_mode) m_cancel <= 1;
    end else if (bus_if.mem_req) begin
      m_busy <= 1; m_fetch <= 0; m_cancel <= 0; m_we <= bus_if.mem_we;
      m_addr <= bus_if.mem_addr; m_wdata <= bus_if.mem_wdata; m_wstrb <= bus_if.mem_wstrb;
    end else if (bus_if.if_req && !bus_if.switch_mode) begin
      m_busy <= 1; m_fetch <= 1; m_cancel <= 0; m_we <= 0;
      m_addr <= bus_if.if_addr; m_wdata <= '0; m_wstrb <= '0;
    end
  end

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    if (chk_on && !rst) begin
      bit done, if_ok, mem_ok;
      done   = m_busy && bus_if.bus_ready;
      if_ok  = done && m_fetch && !m_cancel && !bus_if.switch_mode;
      mem_ok = done && !m_fetch;
      chk("m_bus_valid", 64'(bus_if.bus_valid), 64'(m_busy));
      chk("m_if_stall", 64'(bus_if.if_stall), 64'(bus_if.if_req && !if_ok));
      chk("m_mem_stall", 64'(bus_if.mem_stall), 64'(bus_if.mem_req && !mem_ok));
      chk("m_if_rdata", bus_if.if_rdata, if_ok ? bus_if.bus_rdata : 64'h0);
      chk("m_mem_rdata", bus_if.mem_rdata, (mem_ok && !m_we) ? bus_if.bus_rdata : 64'h0);
      if (m_busy) begin
        chk("m_bus_we", 64'(bus_if.bus_we), 64'(m_we));
        chk("m_bus_addr", bus_if.bus_addr, m_addr);
        chk("m_bus_wdata", bus_if.bus_wdata, m_wdata);
        chk("m_bus_wstrb", 64'(bus_if.bus_wstrb), 64'(m_wstrb));
      end
      if_done_s  = bus_if.if_req && !(bus_if.if_req && !if_ok);
      mem_done_s = bus_if.mem_req && !(bus_if.mem_req && !mem_ok);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus_if.if_req = 0; bus_if.if_addr = '0; bus_if.mem_req = 0; bus_if.mem_we = 0;
    bus_if.mem_addr = '0; bus_if.mem_wdata = '0; bus_if.mem_wstrb = '0;
    bus_if.switch_mode = 0; bus_if.bus_ready = 0; bus_if.bus_rdata = '0;
  endtask

  initial begin
    clear_inputs();
    rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    chk_on = 1;

    // Reset state
    @(negedge clk);
    chk("rst_bus_valid", 64'(bus_if.bus_valid), 64'd0);
    chk("rst_bus_addr", bus_if.bus_addr, 64'd0);
    chk("rst_bus_we", 64'(bus_if.bus_we), 64'd0);
    chk("rst_bus_wstrb", 64'(bus_if.bus_wstrb), 64'd0);
    chk("rst_stalls", 64'({bus_if.if_stall, bus_if.mem_stall}), 64'd0);

    // Minimum-latency fetch
    step(); bus_if.if_req = 1; bus_if.if_addr = 64'h1000;
    @(negedge clk);
    chk("f_grant_stall", 64'(bus_if.if_stall), 64'd1);
    step(); bus_if.bus_ready = 1; bus_if.bus_rdata = 64'h13;
    @(negedge clk);
    chk("f_bus_addr", bus_if.bus_addr, 64'h1000);
    chk("f_done_stall", 64'(bus_if.if_stall), 64'd0);
    chk("f_rdata", bus_if.if_rdata, 64'h13);
    step(); clear_inputs();
    @(negedge clk);
    chk("f_idle_valid", 64'(bus_if.bus_valid), 64'd0);

    // MEM store beats simultaneous fetch
    step(); bus_if.if_req = 1; bus_if.if_addr = 64'h1004;
    bus_if.mem_req = 1; bus_if.mem_we = 1; bus_if.mem_addr = 64'h2000;
    bus_if.mem_wdata = 64'h1122334455667788; bus_if.mem_wstrb = 8'h0F;
    @(negedge clk);
    chk("p_both_stall", 64'({bus_if.if_stall, bus_if.mem_stall}), 64'b11);
    step(); bus_if.bus_ready = 1; bus_if.bus_rdata = 64'hAAAA;
    @(negedge clk);
    chk("p_bus_we", 64'(bus_if.bus_we), 64'd1);
    chk("p_bus_addr", bus_if.bus_addr, 64'h2000);
    chk("p_bus_wstrb", 64'(bus_if.bus_wstrb), 64'h0F);
    chk("p_stalls", 64'({bus_if.if_stall, bus_if.mem_stall}), 64'b10);
    chk("p_store_rdata", bus_if.mem_rdata, 64'h0);
    step(); bus_if.mem_req = 0; bus_if.mem_we = 0; bus_if.bus_ready = 0;
    @(negedge clk);
    chk("p_gap_valid", 64'(bus_if.bus_valid), 64'd0);
    chk("p_gap_if_stall", 64'(bus_if.if_stall), 64'd1);
    step(); bus_if.bus_ready = 1; bus_if.bus_rdata = 64'h55;
    @(negedge clk);
    chk("p_if_addr", bus_if.bus_addr, 64'h1004);
    chk("p_if_rdata", bus_if.if_rdata, 64'h55);
    step(); clear_inputs();

    // Redirect while a fetch is outstanding
    bus_if.if_req = 1; bus_if.if_addr = 64'h3000;
    step();                                    // IF_BUSY, not ready
    step(); bus_if.switch_mode = 1; bus_if.if_addr = 64'h8000_0000;
    @(negedge clk);
    chk("d_sw_stall", 64'(bus_if.if_stall), 64'd1);
    step(); bus_if.switch_mode = 0;
    @(negedge clk);
    chk("d_drop_valid", 64'(bus_if.bus_valid), 64'd1);
    chk("d_drop_addr", bus_if.bus_addr, 64'h3000);
    step(); bus_if.bus_ready = 1; bus_if.bus_rdata = 64'hBAD;
    @(negedge clk);
    chk("d_drop_rdata", bus_if.if_rdata, 64'h0);
    chk("d_drop_stall", 64'(bus_if.if_stall), 64'd1);
    step(); bus_if.bus_ready = 0;
    @(negedge clk);
    chk("d_idle_valid", 64'(bus_if.bus_valid), 64'd0);
    step(); bus_if.bus_ready = 1; bus_if.bus_rdata = 64'h17;
    @(negedge clk);
    chk("d_new_addr", bus_if.bus_addr, 64'h8000_0000);
    chk("d_new_rdata", bus_if.if_rdata, 64'h17);
    step(); clear_inputs();

    // Slow load
    bus_if.mem_req = 1; bus_if.mem_addr = 64'h4000;
    step();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("l_wait_stall", 64'(bus_if.mem_stall), 64'd1);
      chk("l_wait_addr", bus_if.bus_addr, 64'h4000);
      chk("l_wait_rdata", bus_if.mem_rdata, 64'h0);
      step();
    end
    bus_if.bus_ready = 1; bus_if.bus_rdata = 64'hDEADBEEF;
    @(negedge clk);
    chk("l_done_stall", 64'(bus_if.mem_stall), 64'd0);
    chk("l_done_rdata", bus_if.mem_rdata, 64'hDEADBEEF);
    step(); clear_inputs();
    @(negedge clk);
    chk("l_after_rdata", bus_if.mem_rdata, 64'h0);

    // Reset in the middle of a MEM transaction
    step(); bus_if.mem_req = 1; bus_if.mem_addr = 64'h5000; bus_if.if_req = 1;
    bus_if.if_addr = 64'h6000;
    step();
    @(negedge clk);
    chk("r_busy_valid", 64'(bus_if.bus_valid), 64'd1);
    #2 rst = 1;
    #1;
    chk("r_valid_drop", 64'(bus_if.bus_valid), 64'd0);
    chk("r_stalls", 64'({bus_if.if_stall, bus_if.mem_stall}), 64'b11);
    chk("r_bus_addr", bus_if.bus_addr, 64'h0);
    step(); rst = 0; bus_if.mem_req = 0;
    @(negedge clk);
    chk("r_post_valid", 64'(bus_if.bus_valid), 64'd0);
    chk("r_post_stalls", 64'({bus_if.if_stall, bus_if.mem_stall}), 64'b10);
    step(); bus_if.bus_ready = 1; bus_if.bus_rdata = 64'h99;
    @(negedge clk);
    chk("r_post_fetch", bus_if.if_rdata, 64'h99);
    step(); clear_inputs();
    if_done_s = 0; mem_done_s = 0;

    // Randomized traffic against the reference
    for (int c = 0; c < 3000; c++) begin
      step();
      if (!bus_if.if_req || if_done_s) begin
        bus_if.if_req  = ($urandom_range(0, 2) != 0);
        bus_if.if_addr = {$urandom, $urandom};
      end
      if (!bus_if.mem_req || mem_done_s) begin
        bus_if.mem_req   = ($urandom_range(0, 2) == 0);
        bus_if.mem_we    = $urandom_range(0, 1) == 1;
        bus_if.mem_addr  = {$urandom, $urandom};
        bus_if.mem_wdata = {$urandom, $urandom};
        bus_if.mem_wstrb = 8'($urandom);
      end
      bus_if.switch_mode = ($urandom_range(0, 7) == 0);
      if (bus_if.switch_mode) bus_if.if_addr = {$urandom, $urandom};
      bus_if.bus_ready = ($urandom_range(0, 2) == 0);
      bus_if.bus_rdata = {$urandom, $urandom};
      if_done_s = 0; mem_done_s = 0;
      @(negedge clk);
    end

    step();
    chk_on = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
